// File: rtl/lane_seg_mul_pipe_sat.sv
// Pipelined signed multiplier for the lane_seg datapath: full-precision product,
// optional round-half-up, arithmetic right shift, saturate or wrap, with overflow counter.
module lane_seg_mul_pipe_sat #(
  parameter int          ID         = 1,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned din0_WIDTH = 16,
  parameter int unsigned din1_WIDTH = 6,
  parameter int unsigned dout_WIDTH = 22,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned ROUND      = 1,
  parameter int unsigned SAT        = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf,
  input  logic                         cnt_clr,
  output logic [CNT_WIDTH-1:0]         ovf_count
);

  localparam int unsigned P    = din0_WIDTH + din1_WIDTH;
  localparam int unsigned R    = P + 1;
  localparam int unsigned LAST = NUM_STAGE - 1;
  localparam logic signed [R-1:0] RND_ADD =
    (ROUND != 0 && SHIFT > 0) ? (R'(1) << (SHIFT - 1)) : R'(0);

  if (NUM_STAGE < 1 || NUM_STAGE > 8 || SHIFT >= P || dout_WIDTH < 2 || ID < 0) begin : g_bad_param
    $error("lane_seg_mul_pipe_sat: illegal parameter set");
  end

  logic [NUM_STAGE-1:0]         vld;
  logic [NUM_STAGE-1:0]         ld;
  logic [NUM_STAGE-1:0]         up_v;
  logic signed [P-1:0]          prod;
  logic signed [P-1:0]          pp_in;
  logic signed [R-1:0]          r_ext;
  logic signed [R-1:0]          r_rnd;
  logic signed [R-1:0]          r_sh;
  logic signed [dout_WIDTH-1:0] dout_c;
  logic                         ovf_c;
  logic                         out_xfer;

  assign prod = P'(din0) * P'(din1);

  // A stage may load if it or any stage downstream of it is empty, or the sink is ready.
  always_comb begin
    logic rdy;
    ld  = '0;
    rdy = out_ready;
    for (int k = int'(LAST); k >= 0; k--) begin
      rdy   = rdy || !vld[k];
      ld[k] = rdy;
    end
  end

  assign in_ready  = ld[0];
  assign up_v      = NUM_STAGE'({vld, in_valid});
  assign out_valid = vld[LAST];
  assign out_xfer  = vld[LAST] && out_ready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_STAGE); k++) begin
        if (ld[k]) vld[k] <= up_v[k];
      end
    end
  end

  // Product register in S1 followed by plain delay stages up to the last stage input.
  if (NUM_STAGE > 1) begin : g_delay
    logic signed [P-1:0] pdata [NUM_STAGE-1];

    always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
        for (int k = 0; k < int'(LAST); k++) pdata[k] <= '0;
      end else begin
        if (ld[0] && in_valid) pdata[0] <= prod;
        for (int k = 1; k < int'(LAST); k++) begin
          if (ld[k] && vld[k-1]) pdata[k] <= pdata[k-1];
        end
      end
    end

    assign pp_in = pdata[LAST-1];
  end else begin : g_direct
    assign pp_in = prod;
  end

  // The extra headroom bit keeps the rounding add exact.
  always_comb begin
    r_ext = R'(pp_in);
    r_rnd = r_ext + RND_ADD;
    r_sh  = r_rnd >>> SHIFT;
  end

  if (dout_WIDTH >= R) begin : g_wide
    assign ovf_c  = 1'b0;
    assign dout_c = dout_WIDTH'(r_sh);
  end else begin : g_narrow
    localparam logic signed [R-1:0] DMAX = {{(R - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
    localparam logic signed [R-1:0] DMIN = ~DMAX;
    logic signed [dout_WIDTH-1:0] sat_v;

    assign ovf_c  = (r_sh > DMAX) || (r_sh < DMIN);
    assign sat_v  = r_sh[R-1] ? dout_WIDTH'(DMIN) : dout_WIDTH'(DMAX);
    assign dout_c = (SAT != 0 && ovf_c) ? sat_v : r_sh[dout_WIDTH-1:0];
  end

  // Last stage holds its value whenever it is not reloaded.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dout <= '0;
      ovf  <= 1'b0;
    end else if (ld[LAST] && up_v[LAST]) begin
      dout <= dout_c;
      ovf  <= ovf_c;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ovf_count <= '0;
    end else if (cnt_clr) begin
      ovf_count <= '0;
    end else if (out_xfer && ovf && ovf_count != {CNT_WIDTH{1'b1}}) begin
      ovf_count <= ovf_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_lane_seg_mul_pipe_sat.sv
// Directed self-checking bench for lane_seg_mul_pipe_sat: saturating, wrapping
// and 2-bit-counter instances share one stimulus stream.
module tb_lane_seg_mul_pipe_sat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic              cnt_clr;
  logic signed [15:0] din0;
  logic signed [5:0]  din1;

  logic              m_in_ready, m_out_valid, m_ovf;
  logic signed [15:0] m_dout;
  logic [15:0]       m_cnt;
  logic              w_in_ready, w_out_valid, w_ovf;
  logic signed [15:0] w_dout;
  logic [15:0]       w_cnt;
  logic              c_in_ready, c_out_valid, c_ovf;
  logic signed [15:0] c_dout;
  logic [1:0]        c_cnt;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] q_d0[$];
  logic signed [5:0]  q_d1[$];
  int                 q_sd[$];
  int                 q_wd[$];
  int                 q_ov[$];

  lane_seg_mul_pipe_sat #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(6), .dout_WIDTH(16),
    .SHIFT(4), .ROUND(1), .SAT(1), .CNT_WIDTH(16)) u_dut (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .din0(din0), .din1(din1),
    .out_valid(m_out_valid), .out_ready(out_ready), .dout(m_dout), .ovf(m_ovf), .cnt_clr(cnt_clr),
    .ovf_count(m_cnt));

  lane_seg_mul_pipe_sat #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(6), .dout_WIDTH(16),
    .SHIFT(4), .ROUND(1), .SAT(0), .CNT_WIDTH(16)) u_wrap (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .din0(din0), .din1(din1),
    .out_valid(w_out_valid), .out_ready(out_ready), .dout(w_dout), .ovf(w_ovf), .cnt_clr(cnt_clr),
    .ovf_count(w_cnt));

  lane_seg_mul_pipe_sat #(.ID(3), .NUM_STAGE(3), .din0_WIDTH(16), .din1_WIDTH(6), .dout_WIDTH(16),
    .SHIFT(4), .ROUND(1), .SAT(1), .CNT_WIDTH(2)) u_cnt (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .din0(din0), .din1(din1),
    .out_valid(c_out_valid), .out_ready(out_ready), .dout(c_dout), .ovf(c_ovf), .cnt_clr(cnt_clr),
    .ovf_count(c_cnt));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d0, input int d1, input int sd, input int wd, input int ov);
    q_d0.push_back(16'(d0));
    q_d1.push_back(6'(d1));
    q_sd.push_back(sd);
    q_wd.push_back(wd);
    q_ov.push_back(ov);
  endtask

  // Back-to-back stream with out_ready=1; results expected exactly 3 cycles after each transfer.
  task automatic stream();
    int n;
    n = q_d0.size();
    out_ready = 1'b1;
    for (int c = 0; c < n + 4; c++) begin
      if (c >= 3 && c < n + 3) begin
        chk("s_valid", m_out_valid, 1);
        chk("s_dout", m_dout, q_sd[c-3]);
        chk("s_ovf", m_ovf, q_ov[c-3]);
        chk("w_dout", w_dout, q_wd[c-3]);
        chk("w_ovf", w_ovf, q_ov[c-3]);
      end else begin
        chk("s_idle", m_out_valid, 0);
      end
      in_valid = (c < n);
      if (c < n) begin
        din0 = q_d0[c];
        din1 = q_d1[c];
      end
      #1;
      if (c < n) chk("s_in_ready", m_in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    q_d0.delete(); q_d1.delete(); q_sd.delete(); q_wd.delete(); q_ov.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent, rcv;
    logic acc_in, or_t;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", m_out_valid, 0);
    chk("rst_dout", m_dout, 0);
    chk("rst_ovf", m_ovf, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_in_ready", m_in_ready, 1);

    // Latency/throughput: i*16 rounded and shifted by 4 gives back i.
    for (int i = 0; i < 10; i++) push(i, 16, i, i, 0);
    stream();

    // Rounding half-up.
    push(3, 3, 1, 1, 0);
    push(-3, 3, -1, -1, 0);
    push(8, 1, 1, 1, 0);
    push(-8, 1, 0, 0, 0);
    push(7, 1, 0, 0, 0);
    stream();
    chk("round_cnt", m_cnt, 0);

    // Saturation vs wrap: 2^20 -> 65536; -1015808 -> -63488 (wrap 2048).
    push(-32768, -32, 32767, 0, 1);
    push(-32768, 31, -32768, 2048, 1);
    stream();
    chk("sat_cnt", m_cnt, 2);
    chk("sat_cnt2", c_cnt, 2);

    // Backpressure: out_ready low fills the three stages and then blocks.
    out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      din0 = 16'(100 + sent);
      din1 = 6'sd16;
      #1;
      chk("bp_in_ready", m_in_ready, int'(c < 3));
      if (c >= 3) begin
        chk("bp_valid", m_out_valid, 1);
        chk("bp_hold", m_dout, 100);
      end
      acc_in = in_valid && m_in_ready;
      @(posedge clk); #1;
      if (acc_in) sent++;
    end
    chk("bp_sent", sent, 3);

    rcv = 0;
    or_t = 1'b1;
    for (int c = 0; c < 60 && rcv < 8; c++) begin
      out_ready = or_t;
      in_valid = (sent < 8);
      din0 = 16'(100 + sent);
      #1;
      acc_in = in_valid && m_in_ready;
      if (m_out_valid && out_ready) begin
        chk("bp_order", m_dout, 100 + rcv);
        rcv++;
      end
      @(posedge clk); #1;
      if (acc_in) sent++;
      or_t = !or_t;
    end
    chk("bp_count", rcv, 8);
    chk("bp_sent_all", sent, 8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("bp_nodup", m_out_valid, 0);
      @(posedge clk); #1;
    end

    // Reset with three overflowing items stalled in the pipe.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      din0 = -16'sd32768;
      din1 = -6'sd32;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("rst_pre_valid", m_out_valid, 1);
    chk("rst_pre_dout", m_dout, 32767);
    chk("rst_pre_cnt", m_cnt, 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", m_out_valid, 0);
    chk("rst_mid_dout", m_dout, 0);
    chk("rst_mid_ovf", m_ovf, 0);
    chk("rst_mid_cnt", m_cnt, 0);
    chk("rst_mid_wcnt", w_cnt, 0);
    chk("rst_mid_wvalid", w_out_valid, 0);
    chk("rst_mid_cvalid", c_out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rst_stale", m_out_valid, 0);
      chk("rst_in_ready2", m_in_ready, 1);
      chk("rst_w_in_ready", w_in_ready, 1);
      @(posedge clk); #1;
    end

    // Counter saturation on the 2-bit instance.
    for (int i = 0; i < 5; i++) push(-32768, -32, 32767, 0, 1);
    stream();
    chk("cnt_sat", c_cnt, 3);
    chk("cnt_main", m_cnt, 5);
    chk("cnt_c_in_ready", c_in_ready, 1);

    // Clear coinciding with an overflowing output transfer wins.
    in_valid = 1'b1;
    din0 = -16'sd32768;
    din1 = -6'sd32;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_valid", m_out_valid, 1);
    chk("clr_ovf", m_ovf, 1);
    chk("clr_c_ovf", c_ovf, 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_cnt", m_cnt, 0);
    chk("clr_ccnt", c_cnt, 0);
    chk("clr_idle", m_out_valid, 0);
    chk("clr_hold", m_dout, 32767);
    chk("clr_c_hold", c_dout, 32767);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
